mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width of the unified memory.
REQ-002 SHALL have parameter MAX_WAIT, default 3, meaning consecutive denied fetch cycles before fetch wins arbitration.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports if_req input 1 fetch request; if_addr input ADDR_W fetch byte address.
REQ-006 SHALL have ports if_gnt output 1 fetch accepted; if_rvalid output 1 fetch response pulse.
REQ-007 SHALL have ports if_rdata output 32 fetched word; if_err output 1 fetch misaligned, valid with if_rvalid.
REQ-008 SHALL have ports d_req input 1, d_we input 1 (store), d_funct3 input 3, d_addr input ADDR_W, d_wdata input 32.
REQ-009 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output 32, d_err output 1 (misaligned or illegal funct3).
REQ-010 SHALL have memory-side ports mem_read, mem_write output 1; mem_funct3 output 3; mem_addr output ADDR_W; mem_wdata output 32; mem_rdata input 32.

Function
REQ-011 SHALL drive the memory port combinationally from at most one granted requester per cycle; memory read is combinational, memory write commits on the clk edge.
REQ-012 SHALL grant the data port when only d_req is high, and fetch when only if_req is high.
REQ-013 SHALL grant data when both request, except when wait_cnt == MAX_WAIT, in which case fetch is granted.
REQ-014 SHALL increment wait_cnt (saturating at MAX_WAIT) each cycle if_req is high and if_gnt low; SHALL clear it on if_gnt or when if_req is low.
REQ-015 SHALL assert if_gnt/d_gnt in the cycle the request is accepted; requesters hold req and payload stable until gnt.
REQ-016 SHALL drive fetch accesses as mem_read=1, mem_funct3=3'b010 (word), mem_addr=if_addr.
REQ-017 SHALL drive data accesses as mem_read=!d_we, mem_write=d_we, mem_funct3=d_funct3, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-018 SHALL treat as error: fetch with if_addr[1:0]!=0; data with halfword funct3 (001, 101) and addr[0]=1; word funct3 (010) and addr[1:0]!=0; store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}.
REQ-019 SHALL on an error request still assert gnt, keep mem_read=mem_write=0, and pulse the matching err with rvalid next cycle.
REQ-020 SHALL register mem_rdata into if_rdata/d_rdata at the grant edge and pulse the matching rvalid for exactly one cycle, one cycle after gnt.
REQ-021 SHALL pulse d_rvalid one cycle after a granted store (write ack) with d_rdata unchanged.
REQ-022 SHALL hold if_rdata/d_rdata unchanged except on a successful read response.
REQ-023 SHALL track response routing in a registered state resp_sel with states NONE, IF, DATA: next state IF on fetch grant, DATA on data grant, NONE otherwise.
REQ-024 SHALL keep err outputs low whenever the corresponding rvalid is low.
REQ-025 SHALL drive mem_funct3=0, mem_addr=0, mem_wdata=0 when no grant is issued.

Reset
REQ-026 SHALL, while rst is high, force if_gnt, d_gnt, mem_read, mem_write low regardless of requests.
REQ-027 SHALL on reset set resp_sel=NONE, wait_cnt=0, if_rvalid=d_rvalid=0, if_err=d_err=0, if_rdata=d_rdata=0.
REQ-028 SHALL discard any response pending when rst asserts (no rvalid in the cycle after reset deasserts).

Structure
REQ-029 SHALL place funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), the resp_sel state encoding, and default ADDR_W in shared package mem_arb_pkg.
REQ-030 SHALL implement error classification in combinational sub-module mem_align_chk (inputs funct3, addr[1:0], we, is_fetch; output err), instanced once per requester.

Verification
REQ-031 SHALL verify: memory preloaded 0x000020B7 at address 0; if_req, if_addr=0 -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0x000020B7.
REQ-032 SHALL verify: d_req store SW addr 0x40 data 0xDEADBEEF, then LW 0x40 -> d_rvalid after each, d_rdata=0xDEADBEEF; then LB 0x43 -> 0xFFFFFFDE, LBU 0x43 -> 0x000000DE.
REQ-033 SHALL verify: if_req and d_req held high for 6 cycles, data re-requesting each cycle -> d_gnt cycles 0-2, if_gnt cycle 3, d_gnt cycles 4-5.
REQ-034 SHALL verify: LW at 0x42 and LH at 0x41 -> d_err with d_rvalid, mem_read never asserted, d_rdata unchanged; if_addr=0x02 -> if_err.
REQ-035 SHALL verify: rst asserted in the cycle after a LW grant -> no d_rvalid after rst deasserts, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   - funct3 encodings for RV32 loads and stores
//   - resp_sel_e: which requester owns the response in the following cycle
//   - ADDR_W_DEF: default byte-address width of the unified memory
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DATA = 2'd2
  } resp_sel_e;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational access classifier: flags misaligned or illegal accesses.
// Ports:
//   funct3   - access size/sign code (ignored for fetches, which are words)
//   addr     - low two bits of the byte address
//   we       - 1 for a store, 0 for a load
//   is_fetch - 1 when classifying an instruction fetch
//   err      - 1 when the access must not reach memory
module mem_align_chk
  import mem_arb_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       is_fetch,
  output logic       err
);

  logic legal;
  logic misaligned;

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (is_fetch) begin
      legal      = 1'b1;
      misaligned = (addr != 2'b00);
    end else begin
      if (we) begin
        legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      end else begin
        legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
      end
      // Halfwords need an even address, words a 4-byte aligned one.
      misaligned = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr[0]) ||
                   ((funct3 == F3_LW) && (addr != 2'b00));
    end
    err = !legal || misaligned;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch + data) in front of a single
// memory port with combinational read and clocked write.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   if_req/if_addr           - fetch request and byte address
//   if_gnt/if_rvalid/if_rdata/if_err - fetch accept, response pulse, data, error
//   d_req/d_we/d_funct3/d_addr/d_wdata - data request and payload
//   d_gnt/d_rvalid/d_rdata/d_err       - data accept, response pulse, data, error
//   mem_read/mem_write/mem_funct3/mem_addr/mem_wdata/mem_rdata - memory port
//   dbg_resp_sel             - current response-routing state
// Handshake: a requester raises req with a stable payload and holds both
// until gnt is seen high in the same cycle; the access is taken on that
// clock edge and its response (rvalid, plus err/rdata) appears for exactly
// one cycle right after it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output resp_sel_e         dbg_resp_sel
);

  localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

  resp_sel_e        resp_sel_q, resp_sel_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             if_err_q, if_err_d;
  logic             d_err_q, d_err_d;

  logic fetch_win;
  logic data_win;
  logic if_bad;
  logic d_bad;

  mem_align_chk u_if_chk (
    .funct3   (F3_LW),
    .addr     (if_addr[1:0]),
    .we       (1'b0),
    .is_fetch (1'b1),
    .err      (if_bad)
  );

  mem_align_chk u_d_chk (
    .funct3   (d_funct3),
    .addr     (d_addr[1:0]),
    .we       (d_we),
    .is_fetch (1'b0),
    .err      (d_bad)
  );

  // Data has priority; a fetch that has been starved MAX_WAIT cycles wins.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!rst) begin
      fetch_win = if_req && (!d_req || (wait_cnt_q == WAIT_MAX));
      data_win  = d_req && !fetch_win;
    end
  end

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;

  // Memory port: errored grants are accepted but never touch memory.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    if (fetch_win && !if_bad) begin
      mem_read   = 1'b1;
      mem_funct3 = F3_LW;
      mem_addr   = if_addr;
    end else if (data_win && !d_bad) begin
      mem_read   = !d_we;
      mem_write  = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end
  end

  // Next-state for response routing, starvation counter and read data.
  always_comb begin
    resp_sel_d = RESP_NONE;
    wait_cnt_d = '0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_err_d   = 1'b0;
    d_err_d    = 1'b0;
    if (fetch_win) begin
      resp_sel_d = RESP_IF;
    end else if (data_win) begin
      resp_sel_d = RESP_DATA;
    end
    if (if_req && !fetch_win) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
    end
    if (fetch_win) begin
      if_err_d = if_bad;
      if (!if_bad) begin
        if_rdata_d = mem_rdata;
      end
    end
    if (data_win) begin
      d_err_d = d_bad;
      // Store acks leave d_rdata untouched.
      if (!d_bad && !d_we) begin
        d_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sel_q <= RESP_NONE;
      wait_cnt_q <= '0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      resp_sel_q <= resp_sel_d;
      wait_cnt_q <= wait_cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
    end
  end

  assign if_rvalid    = (resp_sel_q == RESP_IF);
  assign d_rvalid     = (resp_sel_q == RESP_DATA);
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_err       = if_err_q;
  assign d_err        = d_err_q;
  assign dbg_resp_sel = resp_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int MAX_WAIT = 3;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic              mem_read, mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  resp_sel_e         dbg_resp_sel;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_resp_sel(dbg_resp_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- memory emulation (byte array, little endian) ----------------
  logic [7:0]  mem [256];
  logic [7:0]  rb0, rb1, rb2, rb3;
  logic        wr_pend;
  logic [2:0]  wr_f3;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    rb0 = mem[mem_addr];
    rb1 = mem[8'(mem_addr + 8'd1)];
    rb2 = mem[8'(mem_addr + 8'd2)];
    rb3 = mem[8'(mem_addr + 8'd3)];
    mem_rdata = 32'h0;
    if (mem_read) begin
      case (mem_funct3)
        3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
        3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
        3'b010:  mem_rdata = {rb3, rb2, rb1, rb0};
        3'b100:  mem_rdata = {24'h0, rb0};
        3'b101:  mem_rdata = {16'h0, rb1, rb0};
        default: mem_rdata = 32'h0;
      endcase
    end
  end

  // Write request captured mid-cycle, committed on the following rising edge.
  initial begin : mem_proc
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hB7; mem[1] = 8'h20; mem[2] = 8'h00; mem[3] = 8'h00;
    forever begin
      @(negedge clk);
      wr_pend = mem_write; wr_f3 = mem_funct3; wr_addr = mem_addr; wr_data = mem_wdata;
      @(posedge clk);
      if (wr_pend) begin
        mem[wr_addr] = wr_data[7:0];
        if (wr_f3 == 3'b001 || wr_f3 == 3'b010) mem[8'(wr_addr + 8'd1)] = wr_data[15:8];
        if (wr_f3 == 3'b010) begin
          mem[8'(wr_addr + 8'd2)] = wr_data[23:16];
          mem[8'(wr_addr + 8'd3)] = wr_data[31:24];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a]; b1 = mem[8'(a + 8'd1)]; b2 = mem[8'(a + 8'd2)]; b3 = mem[8'(a + 8'd3)];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit bad_data(input bit we, input logic [2:0] f3, input logic [7:0] a);
    bit legal, mis;
    if (we) legal = (f3 inside {3'b000, 3'b001, 3'b010});
    else    legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
    return !legal || mis;
  endfunction

  // Scoreboard entry: [35:34] route (0 none, 1 fetch, 2 data, 3 reset),
  // [33] err, [32] rdata updates, [31:0] data.
  logic [35:0] exp_q[$];
  logic [35:0] e;
  logic [1:0]  route;
  int          m_wait = 0;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_d_rdata  = 32'h0;
  logic        x_ig, x_dg, f_bad, dd_bad;
  resp_sel_e   x_sel;

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        route = e[35:34];
        if (route == 2'd3) begin
          m_if_rdata = 32'h0;
          m_d_rdata  = 32'h0;
        end else if (e[32]) begin
          if (route == 2'd1) m_if_rdata = e[31:0];
          else               m_d_rdata  = e[31:0];
        end
        x_sel = (route == 2'd1) ? RESP_IF : (route == 2'd2) ? RESP_DATA : RESP_NONE;
        chk("if_rvalid", if_rvalid, route == 2'd1);
        chk("if_err", if_err, route == 2'd1 && e[33]);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rvalid", d_rvalid, route == 2'd2);
        chk("d_err", d_err, route == 2'd2 && e[33]);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("resp_sel", dbg_resp_sel, x_sel);
      end
      if (rst) begin
        x_ig = 1'b0; x_dg = 1'b0;
      end else if (if_req && d_req) begin
        x_ig = (m_wait >= MAX_WAIT); x_dg = !x_ig;
      end else begin
        x_ig = if_req; x_dg = d_req;
      end
      chk("if_gnt", if_gnt, x_ig);
      chk("d_gnt", d_gnt, x_dg);
      f_bad  = (if_addr[1:0] != 2'b00);
      dd_bad = bad_data(d_we, d_funct3, d_addr);
      if (x_ig && !f_bad) begin
        chk("mem_read", mem_read, 1'b1);
        chk("mem_write", mem_write, 1'b0);
        chk("mem_funct3", mem_funct3, 3'b010);
        chk("mem_addr", mem_addr, if_addr);
      end else if (x_dg && !dd_bad) begin
        chk("mem_read", mem_read, !d_we);
        chk("mem_write", mem_write, d_we);
        chk("mem_funct3", mem_funct3, d_funct3);
        chk("mem_addr", mem_addr, d_addr);
        chk("mem_wdata", mem_wdata, d_wdata);
      end else if (x_ig || x_dg) begin
        chk("mem_read_err", mem_read, 1'b0);
        chk("mem_write_err", mem_write, 1'b0);
      end else begin
        chk("idle_mem_rw", {mem_read, mem_write}, 2'b00);
        chk("idle_mem_bus", {mem_funct3, mem_addr, mem_wdata}, 43'h0);
      end
      if (rst)       exp_q.push_back({2'd3, 34'h0});
      else if (x_ig) exp_q.push_back({2'd1, f_bad, !f_bad, model_load(if_addr, 3'b010)});
      else if (x_dg) exp_q.push_back({2'd2, dd_bad, !dd_bad && !d_we, model_load(d_addr, d_funct3)});
      else           exp_q.push_back(36'h0);
      if (rst || !if_req || x_ig) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic fetch(input logic [7:0] addr, output logic [31:0] rdata,
                       output logic err, output logic got);
    int n;
    n = 0;
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    while (!if_gnt && n < 20) begin n++; @(negedge clk); end
    chk("fetch_gnt_seen", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    rdata = if_rdata; err = if_err; got = if_rvalid;
    @(posedge clk); #1;
  endtask

  task automatic data_access(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output logic got, output logic rw);
    int n;
    n = 0;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    while (!d_gnt && n < 20) begin n++; @(negedge clk); end
    chk("data_gnt_seen", d_gnt, 1'b1);
    rw = mem_read | mem_write;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    rdata = d_rdata; err = d_err; got = d_rvalid;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd;
  logic        er, gv, rw;
  logic [5:0]  pat_i, pat_d;
  logic        if_g_seen, d_g_seen;
  logic [2:0]  load_tbl [5];
  logic [2:0]  store_tbl [3];

  initial begin
    load_tbl  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    store_tbl = '{3'b000, 3'b001, 3'b010};
    rst = 1'b1; if_req = 1'b1; if_addr = 8'h00;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h00; d_wdata = 32'h0;

    // Reset holds everything quiet even with both requests high.
    @(negedge clk);
    chk("rst_gnts", {if_gnt, d_gnt}, 2'b00);
    chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rst_rvalid", {if_rvalid, d_rvalid, if_err, d_err}, 4'h0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    fetch(8'h00, rd, er, gv);
    chk("fetch0_valid", {gv, er}, 2'b10);
    chk("fetch0_data", rd, 32'h000020B7);

    data_access(1'b1, F3_SW, 8'h40, 32'hDEADBEEF, rd, er, gv, rw);
    chk("sw_ack", {gv, er, rw}, 3'b101);
    chk("sw_rdata_held", rd, 32'h0);
    data_access(1'b0, F3_LW, 8'h40, 32'h0, rd, er, gv, rw);
    chk("lw_resp", {gv, er, rw}, 3'b101);
    chk("lw_data", rd, 32'hDEADBEEF);
    data_access(1'b0, F3_LB, 8'h43, 32'h0, rd, er, gv, rw);
    chk("lb_data", rd, 32'hFFFFFFDE);
    data_access(1'b0, F3_LBU, 8'h43, 32'h0, rd, er, gv, rw);
    chk("lbu_data", rd, 32'h000000DE);

    // Misaligned accesses: granted, no memory access, rdata held.
    data_access(1'b0, F3_LW, 8'h42, 32'h0, rd, er, gv, rw);
    chk("lw42_err", {gv, er, rw}, 3'b110);
    chk("lw42_rdata_held", rd, 32'h000000DE);
    data_access(1'b0, F3_LH, 8'h41, 32'h0, rd, er, gv, rw);
    chk("lh41_err", {gv, er, rw}, 3'b110);
    chk("lh41_rdata_held", rd, 32'h000000DE);
    fetch(8'h02, rd, er, gv);
    chk("fetch2_err", {gv, er}, 2'b11);
    chk("fetch2_rdata_held", rd, 32'h000020B7);

    // Contention: both held for six cycles.
    if_req = 1'b1; if_addr = 8'h04;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_LW; d_addr = 8'h40;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat_i[c] = if_gnt; pat_d[c] = d_gnt;
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("contend_d_gnt", pat_d, 6'b110111);
    chk("contend_if_gnt", pat_i, 6'b001000);
    @(posedge clk); #1;

    // Reset right after a LW grant discards the response.
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_LW; d_addr = 8'h40;
    @(negedge clk);
    chk("rst_lw_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_gnts", {if_gnt, d_gnt, mem_read, mem_write}, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {if_rvalid, d_rvalid, if_err, d_err}, 4'h0);
    chk("post_rst_rdata", {if_rdata, d_rdata}, 64'h0);
    chk("post_rst_gnts", {if_gnt, d_gnt}, 2'b00);
    @(posedge clk); #1;

    // Randomized traffic; requesters hold payload until granted.
    if_g_seen = 1'b0; d_g_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || if_g_seen) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
      end
      if (!d_req || d_g_seen) begin
        d_req   = ($urandom_range(0, 99) < 65);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) d_addr[1:0] = 2'b00;
        if ($urandom_range(0, 4) == 0) d_funct3 = 3'($urandom_range(0, 7));
        else if (d_we) d_funct3 = store_tbl[$urandom_range(0, 2)];
        else           d_funct3 = load_tbl[$urandom_range(0, 4)];
        d_wdata = $urandom;
      end
      @(negedge clk);
      if_g_seen = if_gnt; d_g_seen = d_gnt;
      @(posedge clk); #1;
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
